// File: rtl/lstm_seq_scheduler.sv
// lstm_seq_scheduler
//
// Sequences one input sequence through a multi-layer LSTM datapath. On an accepted start it
// optionally clears the per-layer cell (C) and hidden (h) state, then feeds samples to the
// LSTM one at a time, waiting for each result before issuing the next. Results are buffered
// in a small output FIFO tagged with a last flag that marks the final sample of the sequence.
//
// Ports
//   clk, rst           rising-edge clock, synchronous active-high reset
//   start              one-cycle request to begin a sequence (honoured only when idle)
//   seq_len            sequence length, captured on start acceptance (0 completes at once)
//   keep_state         skip the C/h clear, captured on start acceptance
//   busy, done, err    status: busy until idle again, done pulse, sticky stray-result flag
//   x_data/x_valid/x_ready            input sample stream
//   lstm_ready                        LSTM can accept a sample
//   lstm_x_in/lstm_x_in_valid         sample issued to the LSTM
//   lstm_C_in/lstm_h_in               per-layer state clear values (always zero)
//   lstm_C_in_valid/lstm_h_in_valid   per-layer state write strobes
//   lstm_y_out/lstm_valid             LSTM result
//   y_data/y_last/y_valid/y_ready     buffered result stream
module lstm_seq_scheduler #(
  parameter int unsigned LAYERS    = 4,
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MAX_LEN   = 256,
  parameter int unsigned OUT_DEPTH = 4,
  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LEN_W-1:0]        seq_len,
  input  logic                    keep_state,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [WIDTH-1:0]        x_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic                    lstm_ready,
  output logic [WIDTH-1:0]        lstm_x_in,
  output logic                    lstm_x_in_valid,
  output logic [LAYERS*WIDTH-1:0] lstm_C_in,
  output logic [LAYERS*WIDTH-1:0] lstm_h_in,
  output logic [LAYERS-1:0]       lstm_C_in_valid,
  output logic [LAYERS-1:0]       lstm_h_in_valid,
  input  logic [WIDTH-1:0]        lstm_y_out,
  input  logic                    lstm_valid,
  output logic [WIDTH-1:0]        y_data,
  output logic                    y_last,
  output logic                    y_valid,
  input  logic                    y_ready
);

  localparam int unsigned PtrW = $clog2(OUT_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {
    StIdle,
    StClrC,
    StClrH,
    StIssue,
    StWait,
    StDone
  } state_e;

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             c_stb_q;
  logic             h_stb_q;
  logic             err_q;

  logic [WIDTH:0]   mem_q [OUT_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  fifo_cnt_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             x_ready_int;
  logic             x_fire;
  logic [LEN_W-1:0] cnt_inc;
  logic             is_last;
  logic             push;
  logic             pop;
  logic             stray;
  logic             y_valid_int;

  // ---------------------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------------------
  always_comb begin
    fifo_full   = (fifo_cnt_q == CntW'(OUT_DEPTH));
    fifo_empty  = (fifo_cnt_q == '0);
    // Outputs are forced low for the whole time rst is high, including the first reset
    // cycle before the registers have been cleared.
    x_ready_int = (state_q == StIssue) && lstm_ready && !fifo_full && !rst;
    x_fire      = x_valid && x_ready_int;
    cnt_inc     = cnt_q + 1'b1;
    is_last     = (cnt_inc == len_q);
    push        = (state_q == StWait) && lstm_valid && !rst;
    y_valid_int = !fifo_empty && !rst;
    pop         = y_valid_int && y_ready;
    // A result arriving when none is outstanding is dropped and flagged.
    stray       = lstm_valid && (state_q != StWait);
  end

  // ---------------------------------------------------------------------------------------
  // Sequencing FSM with registered status/strobe outputs
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      c_stb_q <= 1'b0;
      h_stb_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      c_stb_q <= 1'b0;
      h_stb_q <= 1'b0;
      if (stray) begin
        err_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            len_q  <= seq_len;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            // Accepting a start clears err unless a stray result lands in the same cycle.
            err_q  <= stray;
            if (seq_len == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else if (keep_state) begin
              state_q <= StIssue;
            end else begin
              state_q <= StClrC;
              c_stb_q <= 1'b1;
            end
          end
        end

        StClrC: begin
          state_q <= StClrH;
          h_stb_q <= 1'b1;
        end

        StClrH: begin
          state_q <= StIssue;
        end

        StIssue: begin
          if (x_fire) begin
            state_q <= StWait;
          end
        end

        StWait: begin
          if (lstm_valid) begin
            cnt_q <= cnt_inc;
            if (is_last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------------------
  // Output FIFO. Pointers wrap naturally since OUT_DEPTH is a power of two. A push can never
  // find the FIFO full: a sample is only issued with a free slot, only one is in flight, and
  // the count cannot grow while waiting for its result.
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {is_last, lstm_y_out};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + 1'b1;
      end else if (pop && !push) begin
        fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  always_comb begin
    busy            = busy_q && !rst;
    done            = done_q && !rst;
    err             = err_q && !rst;
    x_ready         = x_ready_int;
    lstm_x_in       = x_data;
    lstm_x_in_valid = x_fire;
    lstm_C_in       = '0;
    lstm_h_in       = '0;
    lstm_C_in_valid = {LAYERS{c_stb_q && !rst}};
    lstm_h_in_valid = {LAYERS{h_stb_q && !rst}};
    y_data          = mem_q[rd_ptr_q][WIDTH-1:0];
    y_last          = mem_q[rd_ptr_q][WIDTH];
    y_valid         = y_valid_int;
  end

endmodule

// File: tb/tb_lstm_seq_scheduler.sv
// Self-checking bench for lstm_seq_scheduler. A behavioural LSTM responder returns one random
// result a fixed latency after each issued sample; the expected result stream (value plus
// last flag from the sample's index within its sequence) is kept in a queue and compared with
// what is popped from the DUT.
module tb_lstm_seq_scheduler;

  localparam int LAYERS    = 4;
  localparam int WIDTH     = 16;
  localparam int MAX_LEN   = 256;
  localparam int OUT_DEPTH = 4;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [LEN_W-1:0]        seq_len;
  logic                    keep_state;
  logic                    busy, done, err;
  logic [WIDTH-1:0]        x_data;
  logic                    x_valid, x_ready;
  logic                    lstm_ready;
  logic [WIDTH-1:0]        lstm_x_in;
  logic                    lstm_x_in_valid;
  logic [LAYERS*WIDTH-1:0] lstm_C_in, lstm_h_in;
  logic [LAYERS-1:0]       lstm_C_in_valid, lstm_h_in_valid;
  logic [WIDTH-1:0]        lstm_y_out;
  logic                    lstm_valid;
  logic [WIDTH-1:0]        y_data;
  logic                    y_last, y_valid, y_ready;

  always #5 clk = ~clk;

  lstm_seq_scheduler #(
    .LAYERS   (LAYERS),
    .WIDTH    (WIDTH),
    .MAX_LEN  (MAX_LEN),
    .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .seq_len        (seq_len),
    .keep_state     (keep_state),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .x_data         (x_data),
    .x_valid        (x_valid),
    .x_ready        (x_ready),
    .lstm_ready     (lstm_ready),
    .lstm_x_in      (lstm_x_in),
    .lstm_x_in_valid(lstm_x_in_valid),
    .lstm_C_in      (lstm_C_in),
    .lstm_h_in      (lstm_h_in),
    .lstm_C_in_valid(lstm_C_in_valid),
    .lstm_h_in_valid(lstm_h_in_valid),
    .lstm_y_out     (lstm_y_out),
    .lstm_valid     (lstm_valid),
    .y_data         (y_data),
    .y_last         (y_last),
    .y_valid        (y_valid),
    .y_ready        (y_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stimulus knobs
  int lat = 5;
  bit y_rand, xv_rand, lr_rand, spur;

  // Responder / reference model state
  bit             resp_pend, resp_stale;
  int             resp_due, last_resp_cyc;
  int             res_k, cur_len;
  logic [WIDTH:0] exp_q[$];
  logic [WIDTH:0] pop_q[$];

  // Per-sequence observations
  int issues, c_cnt, h_cnt, c_cyc, h_cyc, done_cnt, done_cyc, busy_cnt;
  int first_xr_cyc, first_iss_cyc, t_start;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic observe();
    if (lstm_x_in_valid) begin
      check("x_pass", 32'(lstm_x_in), 32'(x_data));
      check("one_in_flight", 32'(resp_pend), 32'd0);
      if (issues == 0) first_iss_cyc = cyc;
      issues++;
      resp_pend  = 1'b1;
      resp_stale = 1'b0;
      resp_due   = cyc + lat;
    end
    if (x_ready && first_xr_cyc < 0) first_xr_cyc = cyc;
    if (y_valid && y_ready) pop_q.push_back({y_last, y_data});
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (|lstm_C_in_valid) begin
      check("c_all_ones", 32'(lstm_C_in_valid), 32'hF);
      c_cnt++;
      c_cyc = cyc;
    end
    if (|lstm_h_in_valid) begin
      check("h_all_ones", 32'(lstm_h_in_valid), 32'hF);
      h_cnt++;
      h_cyc = cyc;
    end
    if (busy) busy_cnt++;
  endtask

  // Observe the current cycle, advance one clock, then drive the next cycle's inputs.
  task automatic tick();
    #1;
    observe();
    @(posedge clk);
    #1;
    cyc++;
    lstm_valid = 1'b0;
    if (resp_pend && cyc >= resp_due) begin
      lstm_valid = 1'b1;
      lstm_y_out = WIDTH'($urandom);
      resp_pend  = 1'b0;
      if (!resp_stale) begin
        res_k++;
        exp_q.push_back({res_k == cur_len, lstm_y_out});
        last_resp_cyc = cyc;
      end
    end else if (spur) begin
      lstm_valid = 1'b1;
      lstm_y_out = WIDTH'($urandom);
      spur       = 1'b0;
    end
    x_data = WIDTH'($urandom);
    if (xv_rand) x_valid = 1'($urandom);
    if (lr_rand) lstm_ready = ($urandom_range(0, 3) != 0);
    if (y_rand) y_ready = 1'($urandom);
  endtask

  task automatic do_start(input int len, input bit keep);
    issues = 0; c_cnt = 0; h_cnt = 0; c_cyc = -1; h_cyc = -1;
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; first_xr_cyc = -1; first_iss_cyc = -1;
    res_k = 0; cur_len = len;
    seq_len    = LEN_W'(len);
    keep_state = keep;
    start      = 1'b1;
    t_start    = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    tick();
    check("done_once", 32'(done_cnt), 32'd1);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic drain_cmp(input string tag);
    int n = 0;
    y_rand  = 1'b0;
    y_ready = 1'b1;
    while ((y_valid || resp_pend) && n < 60) begin
      tick();
      n++;
    end
    tick();
    check({tag, "_qlen"}, 32'(pop_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < pop_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_data"}, 32'(pop_q[i]), 32'(exp_q[i]));
    end
    pop_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    check("rst_outs_now", 32'({busy, done, err, x_ready, lstm_x_in_valid, |lstm_C_in_valid,
                              |lstm_h_in_valid, y_valid}), 32'd0);
    repeat (n) tick();
    check("rst_outs_held", 32'({busy, done, err, x_ready, lstm_x_in_valid, |lstm_C_in_valid,
                               |lstm_h_in_valid, y_valid}), 32'd0);
    rst = 1'b0;
    if (resp_pend) resp_stale = 1'b1;
    exp_q.delete();
    pop_q.delete();
  endtask

  // Three-sample sequence with clear, x always valid, LSTM latency 5.
  task automatic run_basic(input string tag);
    lat = 5; x_valid = 1'b1; lstm_ready = 1'b1; y_ready = 1'b1;
    do_start(3, 1'b0);
    check({tag, "_err_clr"}, 32'(err), 32'd0);
    wait_done(200);
    check({tag, "_c_cnt"}, 32'(c_cnt), 32'd1);
    check({tag, "_c_cyc"}, 32'(c_cyc), 32'(t_start + 1));
    check({tag, "_h_cnt"}, 32'(h_cnt), 32'd1);
    check({tag, "_h_cyc"}, 32'(h_cyc), 32'(t_start + 2));
    check({tag, "_first_iss"}, 32'(first_iss_cyc), 32'(t_start + 3));
    check({tag, "_issues"}, 32'(issues), 32'd3);
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(last_resp_cyc + 1));
    check({tag, "_state_zero"}, 32'({|lstm_C_in, |lstm_h_in}), 32'd0);
    drain_cmp(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; seq_len = '0; keep_state = 1'b0;
    x_data = '0; x_valid = 1'b0; lstm_ready = 1'b1; lstm_y_out = '0; lstm_valid = 1'b0;
    y_ready = 1'b1; y_rand = 1'b0; xv_rand = 1'b0; lr_rand = 1'b0; spur = 1'b0;
    resp_pend = 1'b0; resp_stale = 1'b0; resp_due = 0; last_resp_cyc = 0;
    res_k = 0; cur_len = 0;

    do_reset(3);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_err", 32'(err), 32'd0);
    check("idle_y_valid", 32'(y_valid), 32'd0);

    // Basic sequence with state clear
    run_basic("b44");

    // Keep state: no strobes, issue window opens the cycle after start
    x_valid = 1'b1;
    lat = $urandom_range(1, 6);
    do_start(2, 1'b1);
    wait_done(200);
    check("keep_first_xr", 32'(first_xr_cyc), 32'(t_start + 1));
    check("keep_strobes", 32'(c_cnt + h_cnt), 32'd0);
    check("keep_issues", 32'(issues), 32'd2);
    drain_cmp("keep");

    // Zero length
    do_start(0, 1'b0);
    wait_done(20);
    check("zero_done_cyc", 32'(done_cyc), 32'(t_start + 1));
    check("zero_busy_cnt", 32'(busy_cnt), 32'd1);
    check("zero_issues", 32'(issues), 32'd0);
    check("zero_strobes", 32'(c_cnt + h_cnt), 32'd0);
    drain_cmp("zero");

    // Back-pressure: FIFO fills to OUT_DEPTH, issuing stalls until one pop
    y_ready = 1'b0;
    lat = $urandom_range(1, 4);
    do_start(6, 1'b0);
    repeat (60) tick();
    check("bp_issues_full", 32'(issues), 32'(OUT_DEPTH));
    check("bp_no_pops", 32'(pop_q.size()), 32'd0);
    check("bp_y_valid", 32'(y_valid), 32'd1);
    check("bp_x_ready", 32'(x_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    y_ready = 1'b1;
    tick();
    y_ready = 1'b0;
    check("bp_one_pop", 32'(pop_q.size()), 32'd1);
    repeat (30) tick();
    check("bp_resume", 32'(issues), 32'(OUT_DEPTH + 1));
    y_rand = 1'b1;
    wait_done(400);
    drain_cmp("bp");

    // Spurious result in idle: flagged, not buffered; next start clears the flag
    y_ready = 1'b0;
    lat = 2;
    do_start(2, 1'b0);
    wait_done(100);
    check("spur_pre_err", 32'(err), 32'd0);
    spur = 1'b1;
    tick();
    tick();
    check("spur_err", 32'(err), 32'd1);
    check("spur_y_valid", 32'(y_valid), 32'd1);
    drain_cmp("spur");
    check("spur_err_sticky", 32'(err), 32'd1);
    do_start(1, 1'b0);
    check("spur_err_clr", 32'(err), 32'd0);
    wait_done(100);
    drain_cmp("spur2");

    // Randomized sequences; the FIFO is not drained between them
    y_rand = 1'b1; xv_rand = 1'b1; lr_rand = 1'b1;
    for (int s = 0; s < 10; s++) begin
      int  len;
      bit  keep;
      len  = $urandom_range(1, 9);
      keep = 1'($urandom);
      lat  = $urandom_range(1, 6);
      do_start(len, keep);
      wait_done(600);
      check("rand_issues", 32'(issues), 32'(len));
      check("rand_c_cnt", 32'(c_cnt), keep ? 32'd0 : 32'd1);
      check("rand_h_cnt", 32'(h_cnt), keep ? 32'd0 : 32'd1);
      check("rand_c_cyc", 32'(c_cyc), keep ? 32'hFFFF_FFFF : 32'(t_start + 1));
      check("rand_err", 32'(err), 32'd0);
    end
    xv_rand = 1'b0; lr_rand = 1'b0; x_valid = 1'b1; lstm_ready = 1'b1;
    drain_cmp("rand");

    // Reset while waiting on a result: sequence abandoned, late result flagged
    y_rand = 1'b0; y_ready = 1'b0; lat = 5; x_valid = 1'b1;
    do_start(3, 1'b0);
    n = 0;
    while (issues < 2 && n < 100) begin
      tick();
      n++;
    end
    check("mid_issues", 32'(issues), 32'd2);
    do_reset(1);
    check("mid_idle", 32'(busy), 32'd0);
    check("mid_y_valid", 32'(y_valid), 32'd0);
    n = 0;
    while (resp_pend && n < 20) begin
      tick();
      n++;
    end
    tick();
    check("mid_late_err", 32'(err), 32'd1);
    check("mid_late_y_valid", 32'(y_valid), 32'd0);
    run_basic("b49");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lstm_seq_scheduler.md
LSTM_SEQ_SCHEDULER -- requirements
Module: lstm_seq_scheduler

Interface
REQ-001 Parameter LAYERS, default 4, number of LSTM layers sequenced.
REQ-002 Parameter WIDTH, default 16, LSTM data width in bits.
REQ-003 Parameter MAX_LEN, default 256, maximum sequence length; LEN_W = $clog2(MAX_LEN+1).
REQ-004 Parameter OUT_DEPTH, default 4, output FIFO depth, power of two and at least 2.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock for all state.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 start  in  1  one-cycle request to begin a sequence.
REQ-009 seq_len  in  LEN_W  number of samples in the sequence, sampled when start is accepted.
REQ-010 keep_state  in  1  when 1, skip the C/h clear; sampled when start is accepted.
REQ-011 busy  out  1  high from start acceptance until the cycle after done.
REQ-012 done  out  1  one-cycle pulse when the last result has been pushed.
REQ-013 err  out  1  sticky flag: lstm_valid seen outside WAIT; cleared on accepted start.
REQ-014 x_data / x_valid / x_ready  in / in / out  WIDTH / 1 / 1  input sample stream.
REQ-015 lstm_ready  in  1  LSTM datapath can accept x.
REQ-016 lstm_x_in / lstm_x_in_valid  out / out  WIDTH / 1  sample issued to the LSTM.
REQ-017 lstm_C_in, lstm_h_in  out  LAYERS*WIDTH  per-layer state values, constant zero.
REQ-018 lstm_C_in_valid, lstm_h_in_valid  out  LAYERS  per-layer state write strobes.
REQ-019 lstm_y_out / lstm_valid  in / in  WIDTH / 1  LSTM result and strobe.
REQ-020 y_data / y_last / y_valid / y_ready  out / out / out / in  WIDTH / 1 / 1 / 1  result stream.

Function
REQ-021 The FSM SHALL have states IDLE, CLR_C, CLR_H, ISSUE, WAIT, DONE.
REQ-022 In IDLE, start SHALL be accepted: if seq_len==0 go to DONE; else if keep_state go to ISSUE; else go to CLR_C.
REQ-023 start outside IDLE SHALL be ignored, with no effect on any state or flag.
REQ-024 CLR_C SHALL assert lstm_C_in_valid all-ones for exactly one cycle, then go to CLR_H.
REQ-025 CLR_H SHALL assert lstm_h_in_valid all-ones for exactly one cycle, then go to ISSUE.
REQ-026 x_ready SHALL equal (state==ISSUE) && lstm_ready && (fifo_count < OUT_DEPTH), combinationally.
REQ-027 lstm_x_in SHALL equal x_data.
REQ-028 lstm_x_in_valid SHALL equal x_valid && x_ready.
REQ-029 An x handshake SHALL move the FSM to WAIT; at most one sample is in flight.
REQ-030 In WAIT, lstm_valid SHALL push {lstm_y_out, last} into the FIFO and increment the sample count.
REQ-031 last SHALL be 1 when the incremented count equals seq_len; the FSM then goes to DONE, else to ISSUE.
REQ-032 DONE SHALL pulse done for one cycle, then go to IDLE; busy SHALL drop in IDLE.
REQ-033 The output FIFO SHALL present its head on y_data/y_last with y_valid = not empty.
REQ-034 A pop SHALL occur on y_valid && y_ready.
REQ-035 A simultaneous push and pop SHALL leave the FIFO count unchanged.
REQ-036 The FIFO pointers SHALL wrap modulo OUT_DEPTH.
REQ-037 The FIFO SHALL persist across sequences; done does not wait for it to drain.
REQ-038 lstm_valid outside WAIT SHALL be dropped, not pushed, and SHALL set err.
REQ-039 With the FIFO full in ISSUE, no sample SHALL be issued (x_ready = 0) until a pop occurs.

Reset
REQ-040 On rst the FSM SHALL go to IDLE.
REQ-041 On rst the FIFO SHALL be emptied and the count cleared.
REQ-042 While rst is high, busy, done, err, x_ready, lstm_x_in_valid, lstm_C_in_valid, lstm_h_in_valid and y_valid SHALL all be 0.
REQ-043 rst mid-sequence SHALL abandon the sequence; a late lstm_valid after reset SHALL set err.

Verification
REQ-044 start, seq_len=3, keep_state=0, x always valid, lstm_ready=1, LSTM latency 5 -> C strobe at T+1, h strobe at T+2, three issues, y_last only on the 3rd result, done once.
REQ-045 keep_state=1, seq_len=2 -> no C/h strobes; the first x_ready occurs at T+1.
REQ-046 seq_len=0 -> done at T+1, no LSTM strobes, busy high for exactly one cycle.
REQ-047 y_ready=0, seq_len=6, OUT_DEPTH=4 -> four results buffered, x_ready held 0, resume after the first pop, order preserved.
REQ-048 Spurious lstm_valid in IDLE -> err=1, FIFO unchanged; next accepted start clears err.
REQ-049 rst asserted in WAIT -> IDLE next cycle, y_valid=0, new start behaves per REQ-044.
